// File: rtl/dbus_sram_responder_pkg.sv
// Shared CPU data-bus definitions: channel request/response structs, uncached FSM states
// and the word-index slice of a byte address.
package dbus_sram_responder_pkg;

  localparam int ADDR_LSB = 2;
  localparam int ADDR_MSB = 15;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [3:0]  byteenable;
  } dbus_req_t;

  typedef struct packed {
    logic        stall;
    logic [31:0] rddata;
  } dbus_rsp_t;

  typedef enum logic [1:0] {
    UC_IDLE = 2'd0,
    UC_WAIT = 2'd1,
    UC_DONE = 2'd2
  } uc_state_e;

endpackage

// File: rtl/dbus_sram_responder_stall_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running every cycle; reloads seed on reset.
module stall_lfsr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= seed;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// SRAM data-bus responder: cached reads return next cycle (LFSR stall injection optional),
// uncached accesses stall UC_LAT+1 cycles then complete; writes merge per byte lane.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 16384,
  parameter int          UC_LAT    = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_en,
  input  logic        c_read,
  input  logic        c_write,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wrdata,
  input  logic [3:0]  c_byteenable,
  output logic        c_stall,
  output logic [31:0] c_rddata,
  input  logic        u_read,
  input  logic        u_write,
  input  logic [31:0] u_addr,
  input  logic [31:0] u_wrdata,
  input  logic [3:0]  u_byteenable,
  output logic        u_stall,
  output logic [31:0] u_rddata,
  output logic [31:0] wr_count
);

  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] DEPTH     = 32'(MEM_WORDS);
  localparam logic [7:0]  WAIT_LAST = 8'(UC_LAT - 1);

  dbus_req_t   c_req, u_req;
  dbus_rsp_t   c_rsp, u_rsp;
  logic [15:0] lfsr;
  logic [31:0] mem [MEM_WORDS];

  logic [AW-1:0] c_idx, u_idx;
  logic          c_req_vld, c_stall_w, c_acc_rd, c_acc_wr;
  logic          u_stall_w, u_done, u_acc_rd, u_acc_wr;

  uc_state_e   uc_state_q, uc_state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] c_rddata_q, c_rddata_d;
  logic [31:0] u_rddata_q, u_rddata_d;
  logic [31:0] wr_count_q, wr_count_d;

  assign c_req = '{read: c_read, write: c_write, addr: c_addr, wrdata: c_wrdata,
                   byteenable: c_byteenable};
  assign u_req = '{read: u_read, write: u_write, addr: u_addr, wrdata: u_wrdata,
                   byteenable: u_byteenable};

  stall_lfsr u_stall_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  // Depth need not be a power of two, so the word index wraps by modulo.
  assign c_idx = AW'(32'(c_req.addr[ADDR_MSB:ADDR_LSB]) % DEPTH);
  assign u_idx = AW'(32'(u_req.addr[ADDR_MSB:ADDR_LSB]) % DEPTH);

  assign c_req_vld = c_req.read | c_req.write;
  assign c_stall_w = rst_n & stall_en & c_req_vld & (lfsr[1:0] == 2'b00);
  assign c_acc_rd  = rst_n & c_req.read  & ~c_stall_w;
  assign c_acc_wr  = rst_n & c_req.write & ~c_stall_w;

  // Requester holds its fields while stalled, so DONE acts on the live request.
  assign u_done   = rst_n & (uc_state_q == UC_DONE);
  assign u_acc_rd = u_done & u_req.read;
  assign u_acc_wr = u_done & u_req.write;

  always_comb begin
    uc_state_d = uc_state_q;
    wait_cnt_d = wait_cnt_q;
    u_stall_w  = 1'b0;
    case (uc_state_q)
      UC_IDLE: begin
        if (u_req.read | u_req.write) begin
          u_stall_w  = 1'b1;
          uc_state_d = UC_WAIT;
          wait_cnt_d = '0;
        end
      end
      UC_WAIT: begin
        u_stall_w = 1'b1;
        if (wait_cnt_q == WAIT_LAST) begin
          uc_state_d = UC_DONE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      UC_DONE: uc_state_d = UC_IDLE;
      default: uc_state_d = UC_IDLE;
    endcase
  end

  always_comb begin
    c_rddata_d = c_rddata_q;
    u_rddata_d = u_rddata_q;
    if (c_acc_rd) c_rddata_d = mem[c_idx];
    if (u_acc_rd) u_rddata_d = mem[u_idx];
    wr_count_d = wr_count_q + 32'(c_acc_wr) + 32'(u_acc_wr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uc_state_q <= UC_IDLE;
      wait_cnt_q <= '0;
      c_rddata_q <= '0;
      u_rddata_q <= '0;
      wr_count_q <= '0;
    end else begin
      uc_state_q <= uc_state_d;
      wait_cnt_q <= wait_cnt_d;
      c_rddata_q <= c_rddata_d;
      u_rddata_q <= u_rddata_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Per lane the cached update is scheduled last, so it wins when both hit one word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (u_acc_wr && u_req.byteenable[i]) mem[u_idx][8*i +: 8] <= u_req.wrdata[8*i +: 8];
      if (c_acc_wr && c_req.byteenable[i]) mem[c_idx][8*i +: 8] <= c_req.wrdata[8*i +: 8];
    end
  end

  assign c_rsp = '{stall: c_stall_w, rddata: c_rddata_q};
  assign u_rsp = '{stall: rst_n & u_stall_w, rddata: u_rddata_q};

  assign c_stall  = c_rsp.stall;
  assign c_rddata = c_rsp.rddata;
  assign u_stall  = u_rsp.stall;
  assign u_rddata = u_rsp.rddata;
  assign wr_count = wr_count_q;

  logic unused_bits;
  assign unused_bits = ^{c_req.addr[31:ADDR_MSB+1], c_req.addr[ADDR_LSB-1:0],
                         u_req.addr[31:ADDR_MSB+1], u_req.addr[ADDR_LSB-1:0], lfsr[15:2]};

endmodule

// File: doc/dbus_sram_responder.md
DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

Interface
REQ-001 The block SHALL have parameters MEM_WORDS (default 16384, word depth), UC_LAT (default 3, uncached wait cycles) and LFSR_SEED (default 16'hACE1, stall-injection seed).
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  sole clock; all state on rising edge
  rst_n  in  1  asynchronous reset, active-low
  stall_en  in  1  enables pseudo-random stall injection on the cached channel
  c_read / c_write  in  1 / 1  cached channel request strobes
  c_addr  in  32  cached byte address; word index = c_addr[15:2]
  c_wrdata  in  32  cached write data
  c_byteenable  in  4  cached byte lanes, bit i = byte i
  c_stall  out  1  cached channel not accepting this cycle
  c_rddata  out  32  cached read data
  u_read / u_write  in  1 / 1  uncached channel request strobes
  u_addr, u_wrdata, u_byteenable  in  32, 32, 4  uncached request fields, same encoding as cached
  u_stall  out  1  uncached channel busy
  u_rddata  out  32  uncached read data
  wr_count  out  32  number of accepted writes, both channels

Function
REQ-003 A cached request (c_read|c_write) SHALL be accepted in the cycle it is presented with c_stall low; the requester holds all fields stable while c_stall is high.
REQ-004 With stall_en high, c_stall SHALL be high in any request cycle where lfsr[1:0]==2'b00; with stall_en low, c_stall SHALL always be 0.
REQ-005 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle regardless of requests.
REQ-006 An accepted cached read SHALL drive c_rddata with the addressed word on the cycle after acceptance; c_rddata SHALL hold that value until the next accepted cached read.
REQ-007 An accepted write SHALL update only the byte lanes with byteenable set; byteenable 4'b0000 SHALL leave memory unchanged but still count as accepted.
REQ-008 Reads SHALL be read-first: a read of a word written in the same cycle returns the old contents.
REQ-009 The uncached channel SHALL use FSM IDLE -> WAIT -> DONE -> IDLE: IDLE->WAIT on u_read|u_write; WAIT counts UC_LAT cycles and then moves to DONE; in DONE the access is performed and the FSM returns to IDLE.
REQ-010 u_stall SHALL be high combinationally in IDLE when a request is present and throughout WAIT, and low in DONE; an uncached access therefore occupies UC_LAT+2 cycles.
REQ-011 u_rddata SHALL be registered on the cycle after DONE and held until the next uncached read completes.
REQ-012 When cached and uncached writes hit the same word in the same cycle, the uncached bytes SHALL be applied first and then the cached enabled bytes, so cached lanes win on overlap.
REQ-013 wr_count SHALL increment by 1 or 2 per cycle (one per accepted write) and wrap at 2^32.
REQ-014 Address bits outside [15:2] SHALL be ignored; indexes at or above MEM_WORDS wrap modulo MEM_WORDS.

Reset
REQ-015 While rst_n is low: c_stall=0, u_stall=0, c_rddata=0, u_rddata=0, wr_count=0, FSM=IDLE, wait counter=0, lfsr=LFSR_SEED; memory contents SHALL NOT be reset.
REQ-016 Reset asserted mid uncached access SHALL abort it with no memory write and no wr_count increment.

Structure
REQ-017 Channel request/response structs (read, write, addr, wrdata, byteenable / stall, rddata) and the uncached FSM state enum SHALL live in the shared CPU defines package.
REQ-018 The LFSR SHALL be a separate sub-module, stall_lfsr, with ports clk, rst_n, seed and q[15:0].

Verification
REQ-019 stall_en=0; cached write 0x0000_0010 <- 0xDEADBEEF, be=4'hF; read 0x10 next cycle -> c_stall never high; c_rddata=0xDEADBEEF one cycle after read acceptance; wr_count=1.
REQ-020 Write 0x20 <- 0x11223344; write 0x20 <- 0xAABBCCDD with be=4'b0101; read -> 0x11BB33DD.
REQ-021 Uncached read 0x30 (preloaded 0x12345678), UC_LAT=3 -> u_stall high 4 cycles, low in DONE; u_rddata=0x12345678 the next cycle.
REQ-022 Same cycle: uncached write 0x40 <- 0xFFFFFFFF be=F (entering DONE) and cached write 0x40 <- 0x00000000 be=4'b0011 -> word=0xFFFF0000; wr_count increments by 2.
REQ-023 stall_en=1, seed 16'hACE1, 1000 back-to-back cached reads -> c_stall matches a reference LFSR model cycle-for-cycle; every returned word is correct.
REQ-024 rst_n pulsed low during WAIT of an uncached write to 0x50 -> 0x50 unchanged, wr_count=0, FSM=IDLE, all outputs at reset values.
